// File: rtl/sobel_window_3x3_if.sv
// Pixel-stream in / 3x3-window out bundle for sobel_window_3x3.
// Both directions are valid-only: a beat transfers on every cycle its valid is high; there is no ready.
interface sobel_window_3x3_if #(
    parameter int PX_SIZE = 8
);
    logic [PX_SIZE-1:0]   input_data;
    logic                 input_data_valid;
    logic [9*PX_SIZE-1:0] window_data;
    logic                 window_valid;
    logic [11:0]          out_col;
    logic [11:0]          out_line;
    logic                 frame_done;

    modport master (
        output input_data, input_data_valid,
        input  window_data, window_valid, out_col, out_line, frame_done
    );

    modport slave (
        input  input_data, input_data_valid,
        output window_data, window_valid, out_col, out_line, frame_done
    );
endinterface

// File: rtl/sobel_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one registered window per interior pixel with its centre coordinates.
module sobel_window_3x3 #(
    parameter int PX_SIZE      = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 resetn,
    sobel_window_3x3_if.slave    bus,
    output logic                 dbg_state_o
);
    localparam int          AW        = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [11:0] LAST_COL  = 12'(IMAGE_WIDTH - 1);
    localparam logic [11:0] LAST_LINE = 12'(IMAGE_HEIGHT - 1);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [11:0]          col_cnt_q, col_cnt_d;
    logic [11:0]          line_cnt_q, line_cnt_d;
    logic [9*PX_SIZE-1:0] win_q, win_d;
    logic                 win_valid_q, win_valid_d;
    logic [11:0]          out_col_q, out_col_d;
    logic [11:0]          out_line_q, out_line_d;
    logic                 frame_done_q, frame_done_d;

    // Line buffers are deliberately not reset; FILL keeps their stale contents hidden.
    logic [PX_SIZE-1:0]   line_a_q [0:IMAGE_WIDTH-1];
    logic [PX_SIZE-1:0]   line_b_q [0:IMAGE_WIDTH-1];

    logic [AW-1:0]        rd_addr;
    logic [PX_SIZE-1:0]   px_a, px_b;
    logic                 end_of_line, end_of_frame, emit;

    assign rd_addr      = col_cnt_q[AW-1:0];
    assign px_a         = line_a_q[rd_addr];
    assign px_b         = line_b_q[rd_addr];
    assign end_of_line  = (col_cnt_q == LAST_COL);
    assign end_of_frame = end_of_line && (line_cnt_q == LAST_LINE);

    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        line_cnt_d   = line_cnt_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_col_d    = out_col_q;
        out_line_d   = out_line_q;
        emit         = 1'b0;

        if (bus.input_data_valid) begin
            if (end_of_frame) begin
                col_cnt_d  = 12'd0;
                line_cnt_d = 12'd0;
            end else if (end_of_line) begin
                col_cnt_d  = 12'd0;
                line_cnt_d = line_cnt_q + 12'd1;
            end else begin
                col_cnt_d  = col_cnt_q + 12'd1;
            end

            // Each window row shifts left; the new right column is {B (top), A (middle), pixel (bottom)}.
            for (int row = 0; row < 3; row++) begin
                win_d[(3*row+0)*PX_SIZE +: PX_SIZE] = win_q[(3*row+1)*PX_SIZE +: PX_SIZE];
                win_d[(3*row+1)*PX_SIZE +: PX_SIZE] = win_q[(3*row+2)*PX_SIZE +: PX_SIZE];
            end
            win_d[2*PX_SIZE +: PX_SIZE] = px_b;
            win_d[5*PX_SIZE +: PX_SIZE] = px_a;
            win_d[8*PX_SIZE +: PX_SIZE] = bus.input_data;

            case (state_q)
                FILL: begin
                    if (end_of_line && (line_cnt_q == 12'd1)) state_d = STREAM;
                end
                STREAM: begin
                    emit = (col_cnt_q >= 12'd2);
                    if (end_of_frame) state_d = FILL;
                end
                default: state_d = FILL;
            endcase
        end

        if (emit) begin
            win_valid_d  = 1'b1;
            frame_done_d = end_of_frame;
            out_col_d    = col_cnt_q - 12'd1;
            out_line_d   = line_cnt_q - 12'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= FILL;
            col_cnt_q    <= 12'd0;
            line_cnt_q   <= 12'd0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            out_col_q    <= 12'd0;
            out_line_q   <= 12'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            line_cnt_q   <= line_cnt_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            out_col_q    <= out_col_d;
            out_line_q   <= out_line_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Read-before-write: px_a/px_b are the old contents at this address.
    always_ff @(posedge clk) begin
        if (bus.input_data_valid) begin
            line_a_q[rd_addr] <= bus.input_data;
            line_b_q[rd_addr] <= px_a;
        end
    end

    assign bus.window_data  = win_q;
    assign bus.window_valid = win_valid_q;
    assign bus.out_col      = out_col_q;
    assign bus.out_line     = out_line_q;
    assign bus.frame_done   = frame_done_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_sobel_window_3x3.sv
// Directed bench for sobel_window_3x3 on a 5x4 image: reset, continuous/gapped frames,
// back-to-back frames and mid-frame reset, checked against hand tables and a window model.
module tb_sobel_window_3x3;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int EW = 16 + 1 + 12 + 12 + 72;

  typedef struct {
    logic [11:0] col;
    logic [11:0] line;
    logic [7:0]  k0;
    logic [7:0]  k4;
    logic [7:0]  k8;
    logic        fd;
  } win_vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic dbg_state;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   fd_cnt = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  sobel_window_3x3_if #(.PX_SIZE(8)) bus ();

  sobel_window_3x3 #(
    .PX_SIZE(8),
    .IMAGE_WIDTH(W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: record every window with the cycle it appeared in
  always @(negedge clk) begin
    if (bus.window_valid) begin
      obs_q.push_back({16'(cyc), bus.frame_done, bus.out_line, bus.out_col, bus.window_data});
      if (bus.frame_done) fd_cnt++;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int base, input int c, input int r);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++)
      w[k*8 +: 8] = 8'(base + 10 * (r - 2 + k / 3) + (c - 2 + k % 3));
    return w;
  endfunction

  // driver tasks
  task automatic drive(input logic [7:0] p, input logic v);
    @(posedge clk);
    #1;
    bus.input_data       = p;
    bus.input_data_valid = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'($urandom_range(0, 255)), 1'b0);
  endtask

  // gap_mode: 0 continuous, 1 alternate idle cycle, 2 random 0..2 idle cycles
  task automatic send_frame(input int base, input int gap_mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(8'(base + 10 * r + c), 1'b1);
        if (r >= 2 && c >= 2)
          exp_q.push_back({16'(cyc + 1), (r == H - 1 && c == W - 1), 12'(r - 1), 12'(c - 1),
                           exp_win(base, c, r)});
        if (gap_mode == 1) idle(1);
        else if (gap_mode == 2) idle($urandom_range(0, 2));
      end
    end
  endtask

  task automatic compare_model(input string name);
    logic [EW-1:0] o, e;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({name, "_win"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_table(input win_vec_t tbl[6]);
    logic [EW-1:0] o;
    for (int i = 0; i < 6; i++) begin
      if (i < obs_q.size()) begin
        o = obs_q[i];
        check("tbl_col", o[83:72], tbl[i].col);
        check("tbl_line", o[95:84], tbl[i].line);
        check("tbl_k0", o[7:0], tbl[i].k0);
        check("tbl_k4", o[39:32], tbl[i].k4);
        check("tbl_k8", o[71:64], tbl[i].k8);
        check("tbl_fd", o[96], tbl[i].fd);
      end else begin
        check("tbl_present", 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    win_vec_t tbl[6];
    logic [EW-1:0] o;
    int fd_before;

    tbl[0] = '{col: 12'd1, line: 12'd1, k0: 8'd0,  k4: 8'd11, k8: 8'd22, fd: 1'b0};
    tbl[1] = '{col: 12'd2, line: 12'd1, k0: 8'd1,  k4: 8'd12, k8: 8'd23, fd: 1'b0};
    tbl[2] = '{col: 12'd3, line: 12'd1, k0: 8'd2,  k4: 8'd13, k8: 8'd24, fd: 1'b0};
    tbl[3] = '{col: 12'd1, line: 12'd2, k0: 8'd10, k4: 8'd21, k8: 8'd32, fd: 1'b0};
    tbl[4] = '{col: 12'd2, line: 12'd2, k0: 8'd11, k4: 8'd22, k8: 8'd33, fd: 1'b0};
    tbl[5] = '{col: 12'd3, line: 12'd2, k0: 8'd12, k4: 8'd23, k8: 8'd34, fd: 1'b1};

    bus.input_data       = 8'd0;
    bus.input_data_valid = 1'b0;

    // reset held with random valid input
    for (int i = 0; i < 5; i++) drive(8'($urandom_range(0, 255)), 1'b1);
    @(negedge clk);
    check("rst_window_data", bus.window_data, 72'd0);
    check("rst_window_valid", bus.window_valid, 1'b0);
    check("rst_out_col", bus.out_col, 12'd0);
    check("rst_out_line", bus.out_line, 12'd0);
    check("rst_frame_done", bus.frame_done, 1'b0);
    check("rst_state", dbg_state, 1'b0);
    drive(8'd0, 1'b0);
    resetn = 1'b1;
    idle(5);
    @(negedge clk);
    check("idle_window_data", bus.window_data, 72'd0);
    check("idle_window_valid", bus.window_valid, 1'b0);
    check("idle_obs_empty", obs_q.size(), 0);

    // small frame, continuous
    fd_before = fd_cnt;
    send_frame(0, 0);
    idle(3);
    check_table(tbl);
    check("small_fd_pulses", fd_cnt - fd_before, 1);
    check("small_state_fill", dbg_state, 1'b0);
    compare_model("small");

    // valid toggling, then random gaps
    fd_before = fd_cnt;
    send_frame(0, 1);
    idle(3);
    check_table(tbl);
    compare_model("gap_toggle");
    send_frame(0, 2);
    idle(3);
    check("gap_fd_pulses", fd_cnt - fd_before, 2);
    compare_model("gap_rand");

    // two back-to-back frames, second offset by 100
    fd_before = fd_cnt;
    send_frame(0, 0);
    send_frame(100, 0);
    idle(3);
    check("wrap_fd_pulses", fd_cnt - fd_before, 2);
    if (obs_q.size() > 6) begin
      o = obs_q[6];
      check("wrap_f2_k0", o[7:0], 8'd100);
      check("wrap_f2_k8", o[71:64], 8'd122);
      check("wrap_f2_centre", {o[95:84], o[83:72]}, {12'd1, 12'd1});
    end else begin
      check("wrap_f2_present", 1'b0, 1'b1);
    end
    compare_model("wrap");

    // reset after 7 pixels, then a clean frame
    for (int i = 0; i < 7; i++) drive(8'(200 + i), 1'b1);
    drive(8'd0, 1'b0);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(2);
    check("midrst_state", dbg_state, 1'b0);
    check("midrst_no_win", obs_q.size(), 0);
    send_frame(0, 0);
    idle(3);
    check_table(tbl);
    compare_model("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sobel_window_3x3.md
# sobel_window_3x3

Streaming 3x3 neighbourhood generator placed directly upstream of the Sobel gradient kernel inside `top_Sobel`. It consumes the raster-order pixel stream (`input_data` / `input_data_valid`, one pixel per valid cycle, line by line, left to right). It buffers the two previous image lines and emits one complete 3x3 window per interior pixel, together with the window-centre coordinates. Border pixels produce no window; border fill to keep the output image at IMAGE_WIDTH x IMAGE_HEIGHT is the job of the downstream kernel stage.

## Interface
- PX_SIZE, 8, pixel width in bits
- IMAGE_WIDTH, 640, pixels per line (must be ≥ 3, ≤ 4095)
- IMAGE_HEIGHT, 480, lines per frame (must be ≥ 3, ≤ 4095)

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- input_data  in  PX_SIZE  incoming pixel, raster order
- input_data_valid  in  1  input_data is valid this cycle; no backpressure
- window_data  out  9*PX_SIZE  packed window; element k = 3*row+col at bits [k*PX_SIZE +: PX_SIZE]; k=0 top-left (oldest), k=8 bottom-right (newest pixel)
- window_valid  out  1  window_data/out_col/out_line valid, one-cycle pulse per window
- out_col  out  12  column of window centre
- out_line  out  12  line of window centre
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame

## Operation
- Counters col_cnt (0..IMAGE_WIDTH-1) and line_cnt (0..IMAGE_HEIGHT-1) give the position of the incoming pixel. They advance only on input_data_valid. col wraps to 0 and increments line; at (W-1, H-1) both wrap to 0 (next frame).
- Line buffers A (row r-1) and B (row r-2): each is IMAGE_WIDTH x PX_SIZE with combinational read at col_cnt. On a valid pixel p at column c: read a=A[c], b=B[c]; write A[c]<=p, B[c]<=a.
- Window registers: three columns of three pixels. On valid: column0<=column1, column1<=column2, column2<={b (top), a (middle), p (bottom)}. Registers are untouched when input_data_valid=0.
- FSM, 2 states:
  - FILL: line_cnt<2; window_valid never asserted. Transition to STREAM when a valid pixel arrives at col=W-1, line=1.
  - STREAM: emit a window for every valid pixel with col_cnt≥2. Transition to FILL on the valid pixel at (W-1, H-1).
- Window emitted for incoming pixel (c, r): centre is out_col=c-1, out_line=r-1; k=8 holds pixel (c, r) and k=0 holds pixel (c-2, r-2).
- Windows spanning a line boundary (col_cnt<2) are suppressed. Stale register contents are never exposed.
- Line buffer contents are not cleared at frame wrap or reset. Stale data is never exposed because the FSM enforces FILL.
- No arithmetic on pixel values; pixels pass unmodified.

## Timing
- Reset (resetn=0, asynchronous): window_data=0, window_valid=0, out_col=0, out_line=0, frame_done=0, col_cnt=0, line_cnt=0, state=FILL. Line buffer RAM is not reset.
- Reset mid-frame: the current frame is abandoned. The next valid pixel after release is treated as pixel (0,0) of a new frame.
- Latency: window outputs are registered and appear 1 cycle after the rising edge that samples the completing pixel.
- window_valid is high for exactly 1 cycle per window. Gaps in input_data_valid produce gaps in window_valid, and window content is unaffected.
- Back-to-back valid input gives back-to-back windows across all interior pixels of a line.
- frame_done and window_valid are both high for the window centred at (W-2, H-2).
- Throughput: 1 pixel/cycle sustained. The combinational read from A/B and write to A/B at the same address in the same cycle must return the old value (read-before-write).
- Windows per frame: (W-2)*(H-2).

## Test plan
- Reset: hold resetn=0 with random input and valid=1 → all outputs 0; release and send no valid → outputs stay 0.
- Small frame: W=5, H=4, pixel = 10*line+col, valid continuous → exactly 6 windows. First window: centre (1,1), k0=0, k4=11, k8=22. Last window: centre (3,2), k0=12, k8=34, with frame_done=1.
- Valid gaps: same W=5, H=4 image with valid toggling 1/0 → identical window sequence, each window_valid 1 cycle after its completing pixel.
- Frame wrap: two back-to-back W=5, H=4 frames, second frame = first+100 → no window during lines 0–1 of frame 2. Frame-2 first window has k0=100, k8=122. frame_done pulses exactly twice.
- Reset mid-frame: assert resetn=0 after 7 pixels, release, send a full W=5, H=4 frame → output identical to the small-frame test.
- Full size: default 640x480, pixel = (col+line) mod 256 → 304964 windows. Centre (638,478) has k8=(639+479) mod 256=94, with frame_done=1.
